// File: rtl/ram_dp_param.sv
// rtl/ram_dp_param.sv - parametrised 1W/1R RAM with read latency, collision policy and clear-on-reset
// Defining RAM_PARITY_EN adds a per-word even-parity bit and the parity_err output.
module ram_dp_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 1,
  parameter int COLL_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  init_busy
`ifdef RAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [MEM_W-1:0]      mem_q [DEPTH];

  logic                  run, wr_ok, rd_ok, rd_in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [MEM_W-1:0]      mem_wdata, wr_word, rd_word;

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];
`ifdef RAM_PARITY_EN
  logic [READ_LATENCY-1:0] perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    run         = (state_q == S_RUN) && !rst;
    wr_ok       = run && wr_en && ({1'b0, wr_addr} < DEPTH_X);
    rd_ok       = run && rd_en;
    rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
`ifdef RAM_PARITY_EN
    wr_word = {^data_in, data_in};
`else
    wr_word = data_in;
`endif
    // Out-of-range reads return zero; write-through mode bypasses the array on a same-address hit
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rd_addr];
      if ((COLL_MODE == 1) && wr_ok && (wr_addr == rd_addr)) rd_word = wr_word;
    end
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_word;
    if (!rst && (state_q == S_INIT)) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    vld_d[0] = rd_ok;
    dat_d[0] = rd_word[DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
    perr_d[0] = ^rd_word;
`endif
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
`ifdef RAM_PARITY_EN
      perr_d[i] = perr_q[i-1];
`endif
    end
    // The output stage only loads on a valid read so data_out holds between pulses
    if (!vld_d[READ_LATENCY-1]) dat_d[READ_LATENCY-1] = dat_q[READ_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
`ifdef RAM_PARITY_EN
      perr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
`ifdef RAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign data_out  = dat_q[READ_LATENCY-1];
  assign rd_valid  = vld_q[READ_LATENCY-1];
  assign init_busy = (state_q == S_INIT);
`ifdef RAM_PARITY_EN
  assign parity_err = vld_q[READ_LATENCY-1] & perr_q[READ_LATENCY-1];
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// tb/tb_ram_dp_param.sv - random and directed bench for ram_dp_param against a cycle-history model
// Four configurations share one stimulus stream: (lat,coll,depth) = (1,0,32) (2,1,32) (3,0,32) (2,1,24).
module tb_ram_dp_param;

  localparam int LAT [4] = '{1, 2, 3, 2};
  localparam int CM  [4] = '{0, 1, 0, 1};
  localparam int DEP [4] = '{32, 32, 32, 24};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [4:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] dout [4];
  logic       rv [4];
  logic       ib [4];
`ifdef RAM_PARITY_EN
  logic       perr [4];
`endif

  always #5 clk = ~clk;

`ifdef RAM_PARITY_EN
  `define TB_PERR(k) , .parity_err(perr[k])
`else
  `define TB_PERR(k)
`endif

  ram_dp_param #(.DATA_WIDTH(8), .DEPTH(32), .READ_LATENCY(1), .COLL_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(dout[0]), .rd_valid(rv[0]), .init_busy(ib[0]) `TB_PERR(0));
  ram_dp_param #(.DATA_WIDTH(8), .DEPTH(32), .READ_LATENCY(2), .COLL_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(dout[1]), .rd_valid(rv[1]), .init_busy(ib[1]) `TB_PERR(1));
  ram_dp_param #(.DATA_WIDTH(8), .DEPTH(32), .READ_LATENCY(3), .COLL_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(dout[2]), .rd_valid(rv[2]), .init_busy(ib[2]) `TB_PERR(2));
  ram_dp_param #(.DATA_WIDTH(8), .DEPTH(24), .READ_LATENCY(2), .COLL_MODE(1)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_addr(rd_addr), .data_out(dout[3]), .rd_valid(rv[3]), .init_busy(ib[3]) `TB_PERR(3));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: each accepted read is recorded with both its pre-write and write-through answers,
  // indexed by clock edge; a DUT of latency L shows the request from L-1 edges earlier.
  typedef struct { bit v; logic [7:0] o; logic [7:0] n; } rd_t;

  logic [7:0] mem  [4][32];
  rd_t        hist [4][8];
  int         rem  [4];
  bit         exp_v [4];
  logic [7:0] exp_d [4];
  bit         exp_b [4];
  bit         started = 1'b0;
  int         e = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      rd_t r, s;
      r.v = 1'b0; r.o = '0; r.n = '0;
      if (rst) begin
        rem[k] = DEP[k];
        for (int a = 0; a < 32; a++) mem[k][a] = '0;
        hist[k][e & 7] = r;
        hist[k][(e - 1) & 7] = r;
        hist[k][(e - 2) & 7] = r;
        exp_v[k] = 1'b0;
        exp_d[k] = '0;
        exp_b[k] = 1'b1;
      end else begin
        if (rem[k] == 0) begin
          if (rd_en) begin
            r.v = 1'b1;
            r.o = (int'(rd_addr) < DEP[k]) ? mem[k][rd_addr] : 8'h00;
            r.n = (wr_en && wr_addr == rd_addr && int'(rd_addr) < DEP[k]) ? data_in : r.o;
          end
          if (wr_en && int'(wr_addr) < DEP[k]) mem[k][wr_addr] = data_in;
        end else begin
          rem[k] = rem[k] - 1;
        end
        hist[k][e & 7] = r;
        s = hist[k][(e - LAT[k] + 1) & 7];
        exp_v[k] = s.v;
        if (s.v) exp_d[k] = (CM[k] == 1) ? s.n : s.o;
        exp_b[k] = (rem[k] != 0);
      end
    end
    if (rst) started = 1'b1;
    e++;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        chk("rd_valid", k, 32'(rv[k]), 32'(exp_v[k]));
        chk("data_out", k, 32'(dout[k]), 32'(exp_d[k]));
        chk("init_busy", k, 32'(ib[k]), 32'(exp_b[k]));
`ifdef RAM_PARITY_EN
        chk("parity_err", k, 32'(perr[k]), 32'(0));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int c0, c3, p0, p2, p3, pr, b0;
  logic [7:0] a3;

  initial begin
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) begin
        hist[k][j].v = 1'b0; hist[k][j].o = '0; hist[k][j].n = '0;
      end

    // Clear sequence, with a write attempted mid-clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c0 = 0; c3 = 0;
    for (int i = 0; i < 60; i++) begin
      wr_en = (i == 5); wr_addr = 5'd3; data_in = 8'hA5;
      if (ib[0]) c0++;
      if (ib[3]) c3++;
      tick();
    end
    wr_en = 1'b0;
    chk("init_busy_cycles_d32", 0, c0, 32);
    chk("init_busy_cycles_d24", 3, c3, 24);

    // Stream every address after clear
    p0 = 0; p2 = 0; p3 = 0; a3 = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      rd_en = (i < 32); rd_addr = 5'(i);
      tick();
      if (rv[0]) begin
        if (p0 == 3) a3 = dout[0];
        p0++;
      end
      if (rv[2]) p2++;
      if (rv[3]) p3++;
    end
    rd_en = 1'b0;
    chk("stream_pulses", 0, p0, 32);
    chk("stream_pulses", 2, p2, 32);
    chk("stream_pulses_oob", 3, p3, 32);
    chk("addr3_ignored_init_write", 0, 32'(a3), 32'h00);

    // Fill with a pattern and stream it back
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); data_in = 8'(i * 7 + 3);
      tick();
    end
    wr_en = 1'b0;
    p0 = 0;
    for (int i = 0; i < 40; i++) begin
      rd_en = (i < 32); rd_addr = 5'(31 - i);
      tick();
      if (rv[1]) p0++;
    end
    rd_en = 1'b0;
    chk("stream_pulses_pattern", 1, p0, 32);

    // Latency 1/2/3
    wr_en = 1'b1; wr_addr = 5'd7; data_in = 8'h5A;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd7;
    tick();
    rd_en = 1'b0;
    chk("lat_valid", 0, 32'(rv[0]), 1);
    chk("lat_data", 0, 32'(dout[0]), 32'h5A);
    chk("lat_early", 1, 32'(rv[1]), 0);
    tick();
    chk("lat_valid", 1, 32'(rv[1]), 1);
    chk("lat_data", 1, 32'(dout[1]), 32'h5A);
    chk("lat_early", 2, 32'(rv[2]), 0);
    tick();
    chk("lat_valid", 2, 32'(rv[2]), 1);
    chk("lat_data", 2, 32'(dout[2]), 32'h5A);

    // Collision then back-to-back read
    wr_en = 1'b1; wr_addr = 5'd9; data_in = 8'h11;
    tick();
    data_in = 8'h22; rd_en = 1'b1; rd_addr = 5'd9;
    tick();
    chk("coll_read_old", 0, 32'(dout[0]), 32'h11);
    wr_en = 1'b0;
    tick();
    chk("back_to_back", 0, 32'(dout[0]), 32'h22);
    chk("coll_write_through", 1, 32'(dout[1]), 32'h22);
    chk("coll_write_through", 3, 32'(dout[3]), 32'h22);
    rd_en = 1'b0;
    tick();
    chk("coll_read_old", 2, 32'(dout[2]), 32'h11);

    // Reset while a read is in flight
    rd_en = 1'b1; rd_addr = 5'd5;
    tick();
    rd_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    pr = 0; b0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (ib[0]) b0++;
      if (rv[1] || rv[2]) pr++;
      tick();
    end
    chk("rst_discards_inflight", 2, pr, 0);
    chk("rst_reclear_cycles", 0, b0, 32);

    // Randomised traffic with rare resets and a hot address window for collisions
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(8, 11)) : 5'($urandom_range(0, 31));
      rd_addr = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(8, 11)) : 5'($urandom_range(0, 31));
      data_in = 8'($urandom);
      tick();
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
